// File: rtl/keypad_time_entry.sv
// keypad_time_entry: debounced keypad digit entry into a 4-digit BCD buffer
// ({min_tens, min_ones, sec_tens, sec_ones}) with commit to time_out.
// Optional build macro SECONDS_CLAMP_EN: clamp a committed sec_tens > 5 to 59 seconds.
module keypad_time_entry #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  D,
   input  logic        valid,
   input  logic        enablen,
   input  logic        start,
   input  logic        clear,
   output logic [15:0] entry,
   output logic [2:0]  digit_count,
   output logic [15:0] time_out,
   output logic        load,
   output logic        key_ack
);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, CAPTURE, HOLD} state_t;

   localparam logic [8:0] DB_LIMIT = 9'(DEBOUNCE_CYCLES);

   state_t      state;
   logic [7:0]  cnt;
   logic [3:0]  code;
   logic [8:0]  cnt_next;
   logic        do_commit;
   logic        do_capture;
   logic [15:0] commit_val;

   // Event qualification: clear beats commit, and both beat a digit capture.
   always_comb begin
      cnt_next   = {1'b0, cnt} + 9'd1;
      do_commit  = start && enablen && (entry != '0) && !clear;
      do_capture = (state == CAPTURE) && enablen && (code <= 4'd9) && !clear && !do_commit;
   end

   // Value written to time_out on a commit.
   always_comb begin
      commit_val = entry;
`ifdef SECONDS_CLAMP_EN
      if (entry[7:4] > 4'd5)
         commit_val = {entry[15:8], 8'h59};
`endif
   end

   // Key debounce FSM; enablen low parks it in IDLE so a held key must re-debounce.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         code  <= '0;
      end else if (!enablen) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (valid) begin
                  state <= DEBOUNCE;
                  cnt   <= 8'd1;
                  code  <= D;
               end
            end
            DEBOUNCE: begin
               if (!valid || (D != code)) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt_next[7:0];
                  if (cnt_next >= DB_LIMIT)
                     state <= CAPTURE;
               end
            end
            CAPTURE: begin
               state <= HOLD;
               cnt   <= '0;
            end
            HOLD: begin
               if (!valid)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Entry buffer, digit count, committed time and the one-cycle event pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         entry       <= '0;
         digit_count <= '0;
         time_out    <= '0;
         load        <= 1'b0;
         key_ack     <= 1'b0;
      end else begin
         load    <= 1'b0;
         key_ack <= 1'b0;
         if (clear) begin
            entry       <= '0;
            digit_count <= '0;
         end else if (do_commit) begin
            time_out    <= commit_val;
            load        <= 1'b1;
            entry       <= '0;
            digit_count <= '0;
         end else if (do_capture) begin
            entry   <= {entry[11:0], code};
            key_ack <= 1'b1;
            if (digit_count < 3'd4)
               digit_count <= digit_count + 3'd1;
         end
      end
   end

endmodule
